mux_nto1_rr: RTL and testbench

Parametrised N:1 data selector with a registered output stage, valid/ready handshakes and two selection modes. MODE=0 selects by an explicit index; MODE=1 uses round-robin arbitration. Sits between multiple RV32I datapath or peripheral producers (writeback sources, bus masters) and a single consumer. It replaces fixed 4:1 combinational muxes wherever back-pressure or fair sharing is needed.

---
 rtl/mux_nto1_rr.sv | 101 ++++++++++
 tb/tb_mux_nto1_rr.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr: N:1 selector with registered output, valid/ready handshakes, index or round-robin mode.
// Optional MUX_LOCK_EN adds per-channel lock requests that hold the round-robin grant on one channel.
module mux_nto1_rr #(
  parameter int WIDTH = 32,
  parameter int N = 4,
  localparam int SELW = (N > 2) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode_i,
  input  logic [SELW-1:0]    sel_i,
  input  logic [N*WIDTH-1:0] in_data_i,
  input  logic [N-1:0]       in_valid_i,
`ifdef MUX_LOCK_EN
  input  logic [N-1:0]       in_lock_i,
`endif
  output logic [N-1:0]       in_ready_o,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [SELW-1:0]    out_ch_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0] ch_q, ch_d, ptr_q, ptr_d, gidx;
  logic [N-1:0] gnt, rr_gnt, sel_gnt;
  logic [WIDTH-1:0] ch_data [N];
  logic load, xfer;
  for (genvar k = 0; k < N; k++) begin : g_ch
    assign ch_data[k] = in_data_i[k*WIDTH +: WIDTH];
  end
  // Scan backwards so the first valid channel at or after p (mod N) wins.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input logic [SELW-1:0] p);
    rr_pick = '0;
    for (int i = N-1; i >= 0; i--) begin
      int j;
      j = (int'(p) + i) % N;
      if (v[j]) begin
        rr_pick = '0;
        rr_pick[j] = 1'b1;
      end
    end
  endfunction
  always_comb begin
    sel_gnt = '0;
    if (int'(sel_i) < N) sel_gnt[sel_i] = in_valid_i[sel_i];
  end
`ifdef MUX_LOCK_EN
  logic locked_q, locked_d;
  logic [SELW-1:0] lock_ch_q, lock_ch_d;
  logic [N-1:0] lock_gnt;
  always_comb begin
    lock_gnt = '0;
    lock_gnt[lock_ch_q] = 1'b1;
  end
  assign rr_gnt = locked_q ? lock_gnt : rr_pick(in_valid_i, ptr_q);
  assign locked_d = !mode_i ? 1'b0 : (xfer ? in_lock_i[gidx] : locked_q);
  assign lock_ch_d = (xfer && mode_i) ? gidx : lock_ch_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      locked_q <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      locked_q <= locked_d;
      lock_ch_q <= lock_ch_d;
    end
`else
  assign rr_gnt = rr_pick(in_valid_i, ptr_q);
`endif
  assign gnt = mode_i ? rr_gnt : sel_gnt;
  assign load = (state_q == EMPTY) || out_ready_i;
  assign in_ready_o = rst_n ? (gnt & {N{load}}) : '0;
  assign xfer = |(in_valid_i & in_ready_o);
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++)
      if (gnt[i]) gidx = SELW'(i);
  end
  always_comb begin
    state_d = xfer ? FULL : (out_ready_i ? EMPTY : state_q);
    data_d = xfer ? ch_data[gidx] : data_q;
    ch_d = xfer ? gidx : ch_q;
    ptr_d = (xfer && mode_i) ? ((gidx == SELW'(N-1)) ? '0 : gidx + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q <= '0;
      ch_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      ch_q <= ch_d;
      ptr_q <= ptr_d;
    end
  assign out_valid_o = (state_q == FULL);
  assign out_data_o = data_q;
  assign out_ch_o = ch_q;
endmodule

// File: tb/tb_mux_nto1_rr.sv
// tb_mux_nto1_rr: vector table, hand sequences and randomized traffic against a cycle model.
// Build with MUX_LOCK_EN defined to also exercise channel locking.
module tb_mux_nto1_rr;
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  logic mode = 0, ordy = 0;
  logic [1:0] sel = 0;
  logic [127:0] in_d = '0;
  logic [3:0] in_v = '0, lock_v = '0, in_rdy;
  logic [31:0] out_d;
  logic [1:0] out_c;
  logic out_v;
  logic mode3 = 0, ordy3 = 0;
  logic [1:0] sel3 = 0, oc3;
  logic [95:0] in_d3 = {32'h3002, 32'h3001, 32'h3000};
  logic [2:0] v3 = '0, rdy3;
  logic [31:0] od3;
  logic ov3;
  int n_cmp = 0, n_err = 0;
  bit chk_en = 0;

  mux_nto1_rr #(.WIDTH(32), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode), .sel_i(sel), .in_data_i(in_d), .in_valid_i(in_v),
`ifdef MUX_LOCK_EN
    .in_lock_i(lock_v),
`endif
    .in_ready_o(in_rdy), .out_data_o(out_d), .out_ch_o(out_c), .out_valid_o(out_v), .out_ready_i(ordy));

  mux_nto1_rr #(.WIDTH(32), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode_i(mode3), .sel_i(sel3), .in_data_i(in_d3), .in_valid_i(v3),
`ifdef MUX_LOCK_EN
    .in_lock_i(3'b000),
`endif
    .in_ready_o(rdy3), .out_data_o(od3), .out_ch_o(oc3), .out_valid_o(ov3), .out_ready_i(ordy3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a word slot, a pointer and a lock, stepped from the arbitration rules.
  logic m_v = 0, m_lk = 0;
  logic [31:0] m_d = '0;
  int m_c = 0, m_ptr = 0, m_lc = 0, mg;
  logic m_load, m_xfer;
  logic [3:0] m_rdy;
  function automatic int m_grant(input logic md, input logic [1:0] s, input logic [3:0] v,
                                 input int p, input logic lk, input int lc);
    if (!md) return v[s] ? int'(s) : -1;
    if (lk) return lc;
    for (int i = 0; i < 4; i++) if (v[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction
  always_comb begin
    mg = m_grant(mode, sel, in_v, m_ptr, m_lk, m_lc);
    m_load = !m_v || ordy;
    m_xfer = (mg >= 0) && m_load && in_v[mg];
    m_rdy = (rst_n && mg >= 0 && m_load) ? 4'(1 << mg) : 4'b0;
  end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_v <= 0; m_d <= '0; m_c <= 0; m_ptr <= 0; m_lk <= 0; m_lc <= 0;
    end else begin
      if (m_xfer) begin
        m_v <= 1; m_d <= in_d[mg*32 +: 32]; m_c <= mg;
        if (mode) begin
          m_ptr <= (mg + 1) % 4; m_lk <= lock_v[mg]; m_lc <= mg;
        end
      end else if (ordy) m_v <= 0;
      if (!mode) m_lk <= 0;
    end
  always @(negedge clk)
    if (chk_en) begin
      chk("mdl_valid", 32'(out_v), 32'(m_v));
      chk("mdl_data", out_d, m_d);
      chk("mdl_ch", 32'(out_c), 32'(m_c));
      chk("mdl_ready", 32'(in_rdy), 32'(m_rdy));
    end

  typedef struct packed {
    logic md; logic [1:0] s; logic [3:0] v; logic r;
    logic [3:0] e_rdy; logic e_v; logic [1:0] e_c; logic [31:0] e_d;
  } vec_t;
  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic std_data();
    for (int k = 0; k < 4; k++) in_d[k*32 +: 32] = 32'h1000 + k;
  endtask

  initial begin
    logic [2:0] r3 [4];
    logic [1:0] c3 [4];
    r3 = '{3'b001, 3'b100, 3'b001, 3'b100};
    c3 = '{2'd0, 2'd2, 2'd0, 2'd2};
    // MODE=0 selection, drain, back-pressure, then round-robin fairness.
    tbl.push_back('{0, 2, 4'hF, 1, 4'b0100, 1, 2, 32'h1002});
    tbl.push_back('{0, 3, 4'h7, 1, 4'b0000, 0, 2, 32'h1002});
    tbl.push_back('{0, 1, 4'hF, 1, 4'b0010, 1, 1, 32'h1001});
    tbl.push_back('{0, 2, 4'hF, 0, 4'b0000, 1, 1, 32'h1001});
    tbl.push_back('{0, 2, 4'hF, 0, 4'b0000, 1, 1, 32'h1001});
    tbl.push_back('{0, 2, 4'hF, 0, 4'b0000, 1, 1, 32'h1001});
    tbl.push_back('{0, 2, 4'hF, 1, 4'b0100, 1, 2, 32'h1002});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1, 0, 4'hF, 1, 4'(1 << (i % 4)), 1, 2'(i % 4), 32'h1000 + 32'(i % 4)});
    tbl.push_back('{1, 0, 4'h0, 1, 4'b0000, 0, 3, 32'h1003});
    std_data();
    mode = 0; sel = 0; in_v = 4'hF;
    #2 rst_n = 0;
    #1;
    chk("rst_valid", 32'(out_v), 0);
    chk("rst_data", out_d, 0);
    chk("rst_ch", 32'(out_c), 0);
    chk("rst_ready", 32'(in_rdy), 0);
    #9 rst_n = 1;
    in_v = 0;
    tick();
    chk_en = 1;
    foreach (tbl[i]) begin
      mode = tbl[i].md; sel = tbl[i].s; in_v = tbl[i].v; ordy = tbl[i].r;
      @(negedge clk);
      chk($sformatf("row%0d_ready", i), 32'(in_rdy), 32'(tbl[i].e_rdy));
      tick();
      chk($sformatf("row%0d_valid", i), 32'(out_v), 32'(tbl[i].e_v));
      chk($sformatf("row%0d_ch", i), 32'(out_c), 32'(tbl[i].e_c));
      chk($sformatf("row%0d_data", i), out_d, tbl[i].e_d);
    end
    // Asynchronous reset while holding a word; the pointer is non-zero beforehand.
    mode = 1; in_v = 4'b0010; ordy = 1;
    tick();
    mode = 0; sel = 0; in_v = 4'b0001; in_d[31:0] = 32'hDEADBEEF;
    tick();
    ordy = 0;
    tick();
    chk("pre_rst_data", out_d, 32'hDEADBEEF);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(out_v), 0);
    chk("mid_rst_data", out_d, 0);
    chk("mid_rst_ch", 32'(out_c), 0);
    chk("mid_rst_ready", 32'(in_rdy), 0);
    #1 rst_n = 1;
    std_data();
    mode = 1; in_v = 4'hF; ordy = 1;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_rdy), 32'b0001);
    tick();
    chk("post_rst_ch", 32'(out_c), 0);
    in_v = 0;
    // Three channels, only 0 and 2 valid: grants alternate and the pointer wraps.
    mode3 = 1; v3 = 3'b101; ordy3 = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("n3_ready%0d", i), 32'(rdy3), 32'(r3[i]));
      tick();
      chk($sformatf("n3_ch%0d", i), 32'(oc3), 32'(c3[i]));
      chk($sformatf("n3_data%0d", i), od3, 32'h3000 + 32'(c3[i]));
    end
    mode3 = 0; sel3 = 3; v3 = 3'b111;
    @(negedge clk);
    chk("n3_sel_oob_ready", 32'(rdy3), 0);
    tick();
    chk("n3_sel_oob_valid", 32'(ov3), 0);
    v3 = 0;
`ifdef MUX_LOCK_EN
    begin
      logic [3:0] lv [4], vv [4];
      logic [1:0] lc [4];
      lv = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
      vv = '{4'b0010, 4'b1111, 4'b1111, 4'b1111};
      lc = '{2'd1, 2'd1, 2'd1, 2'd2};
      mode = 1; ordy = 1;
      for (int i = 0; i < 4; i++) begin
        lock_v = lv[i]; in_v = vv[i];
        tick();
        chk($sformatf("lock_ch%0d", i), 32'(out_c), 32'(lc[i]));
      end
      lock_v = 0; in_v = 0;
    end
`endif
    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel = 2'($urandom_range(0, 3));
      in_v = 4'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) in_d[k*32 +: 32] = $urandom;
      tick();
    end
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
